riscv_trace_buffer: RTL and testbench
=====================================

Name: riscv_trace_buffer

Overview:
- Parametrised retire-trace capture block for the RISC-V core; turns the PC/instruction/writeback monitoring done at simulation level into synthesizable on-chip debug logic.
- Snoops one retired instruction per cycle into a circular buffer of DEPTH entries.
- Supports a PC-match trigger with a programmable post-trigger window.
- Once capture stops, the trace is read out oldest-first over a valid/ready handshake.

Parameters:
XLEN, 32, width of PC and writeback data.
DEPTH, 16, number of trace entries; power of 2, ≥ 2.
POST_TRIG, 4, entries captured after the trigger entry; 0 to DEPTH-1.
AW, log2(DEPTH), derived pointer width; not overridable.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
cap_valid  in  1  one instruction retires this cycle.
cap_pc  in  XLEN  PC of retiring instruction.
cap_instr  in  32  retiring instruction word.
cap_wdata  in  XLEN  register writeback data.
arm  in  1  single-cycle pulse; start a new capture.
trig_en  in  1  enable PC-match trigger.
trig_pc  in  XLEN  trigger PC.
rd_ready  in  1  consumer accepts the current rd_* entry.
rd_valid  out  1  rd_* holds a valid unread entry.
rd_pc  out  XLEN  entry PC.
rd_instr  out  32  entry instruction.
rd_wdata  out  XLEN  entry writeback data.
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
count  out  AW+1  entries held, 0..DEPTH.
overflow  out  1  buffer wrapped since last arm.
retire_cnt  out  32  free-running count of cap_valid cycles.

Behaviour:
- Reset (synchronous):
  - state=IDLE; count=0; overflow=0; retire_cnt=0; rd_valid=0; rd_* = 0.
  - Write pointer and post counter cleared.
  - Reset wins over every other input in the same cycle.
- retire_cnt: increments on every cap_valid cycle in all states; wraps 0xFFFFFFFF→0.
- IDLE:
  - No capture.
  - arm → ARMED next cycle; clears count, overflow and pointers.
  - A cap_valid in the arm cycle is not captured.
- ARMED:
  - Each cap_valid writes {cap_pc, cap_instr, cap_wdata} at wr_ptr; wr_ptr increments mod DEPTH.
  - count += 1, saturating at DEPTH.
  - A write when count==DEPTH overwrites the oldest entry and sets overflow=1 (sticky until arm or reset).
- Trigger:
  - Fires when state==ARMED && trig_en && cap_valid && cap_pc==trig_pc.
  - The trigger entry itself is captured.
  - If POST_TRIG==0 → DONE next cycle; else → POST with post_cnt=POST_TRIG.
- POST:
  - Captures exactly as ARMED.
  - Each captured entry decrements post_cnt; the write that takes post_cnt to 0 moves state → DONE next cycle.
  - The trigger is not re-evaluated in POST.
- DONE:
  - No capture.
  - rd_valid = (count != 0).
  - rd_* present the entry at rd_ptr = wr_ptr − count (mod DEPTH), i.e. the oldest entry.
  - Handshake: transfer when rd_valid && rd_ready; count decrements next cycle and the next-oldest entry appears.
  - rd_* stay stable while rd_valid && !rd_ready.
  - rd_valid never asserts outside DONE.
- Capture timing: an entry captured at edge N is reflected in count after edge N.
- arm in ARMED, POST or DONE:
  - Restarts capture (→ ARMED); clears count and overflow.
  - Unread entries are discarded.
  - arm takes priority over a simultaneous trigger or transfer.
- trig_en=0: block stays in ARMED indefinitely as a rolling last-DEPTH history.
- Buffer storage is not reset; only pointers and count are.

Test Plan:
1. Reset asserted 2 cycles → state=0, count=0, rd_valid=0, overflow=0, retire_cnt=0, rd_* = 0.
2. arm; retire PCs 0x00,0x04,…,0x20 (9 instrs); trig_pc=0x10, POST_TRIG=4 → trigger at 0x10, DONE after 0x20; count=9, overflow=0; rd_ready=1 reads PCs 0x00..0x20 in order with matching instr/wdata; count reaches 0, rd_valid=0.
3. DEPTH=16; arm; retire 21 instrs with PCs 0x00..0x50; trig_pc=0x40, POST_TRIG=4 → DONE; count=16, overflow=1; first read PC=0x14, last read PC=0x50.
4. In DONE with count=3, hold rd_ready=0 for 3 cycles → rd_valid=1 and rd_pc constant; then toggle rd_ready 1/0/1 → exactly 2 entries consumed, count=1.
5. Reset asserted in POST with post_cnt=2 → next cycle state=IDLE, count=0, rd_valid=0, retire_cnt=0; following cap_valid pulses not captured until arm.
6. POST_TRIG=0, trigger on PC 0x08 → DONE the next cycle with newest entry 0x08; arm in DONE with count=5 → state=ARMED, count=0, rd_valid=0; a simultaneous cap_valid is not captured.

Source files
------------

// File: rtl/riscv_trace_buffer_if.sv
// Retire-snoop and trace-readout signal bundle for riscv_trace_buffer.
//   cap_valid/cap_pc/cap_instr/cap_wdata : one retired instruction per cycle
//   rd_valid/rd_ready                    : readout handshake
//   rd_pc/rd_instr/rd_wdata              : oldest unread trace entry
// master: the core/debug side (drives capture, accepts readout)
// slave : the trace buffer
interface riscv_trace_buffer_if #(
   parameter int XLEN = 32
) ();
   logic            cap_valid;
   logic [XLEN-1:0] cap_pc;
   logic [31:0]     cap_instr;
   logic [XLEN-1:0] cap_wdata;
   logic            rd_ready;
   logic            rd_valid;
   logic [XLEN-1:0] rd_pc;
   logic [31:0]     rd_instr;
   logic [XLEN-1:0] rd_wdata;

   modport master (
      output cap_valid, cap_pc, cap_instr, cap_wdata, rd_ready,
      input  rd_valid, rd_pc, rd_instr, rd_wdata
   );

   modport slave (
      input  cap_valid, cap_pc, cap_instr, cap_wdata, rd_ready,
      output rd_valid, rd_pc, rd_instr, rd_wdata
   );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Retire-trace capture buffer.
// Snoops one retired instruction per cycle into a DEPTH-entry circular
// buffer. A PC-match trigger ends capture POST_TRIG entries later; the
// trace is then read out oldest-first over a valid/ready handshake.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : capture inputs and readout handshake/data
//   arm            : one-cycle pulse, restart capture from empty
//   trig_en/trig_pc: PC-match trigger enable and address
//   state          : 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count          : entries held, 0..DEPTH
//   overflow       : buffer wrapped since last arm
//   retire_cnt     : free-running count of cap_valid cycles
module riscv_trace_buffer #(
   parameter  int XLEN      = 32,
   parameter  int DEPTH     = 16,
   parameter  int POST_TRIG = 4,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   riscv_trace_buffer_if.slave    bus,
   input  logic                   arm,
   input  logic                   trig_en,
   input  logic [XLEN-1:0]        trig_pc,
   output logic [1:0]             state,
   output logic [AW:0]            count,
   output logic                   overflow,
   output logic [31:0]            retire_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_POST  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [31:0]     instr_mem [DEPTH];
   logic [XLEN-1:0] wdata_mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] post_cnt;
   logic          cap_en;
   logic          trig_hit;
   logic          full;
   logic          rd_fire;

   // arm suppresses the capture in its own cycle, whatever the state.
   assign cap_en   = (state == S_ARMED || state == S_POST) && bus.cap_valid && !arm;
   assign trig_hit = (state == S_ARMED) && trig_en && bus.cap_valid &&
                     (bus.cap_pc == trig_pc);
   assign full     = (count == (AW+1)'(DEPTH));
   assign rd_fire  = bus.rd_valid && bus.rd_ready;
   // When full, count[AW-1:0] is 0 and rd_ptr == wr_ptr, the oldest slot.
   assign rd_ptr   = wr_ptr - count[AW-1:0];

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         pc_mem[wr_ptr]    <= bus.cap_pc;
         instr_mem[wr_ptr] <= bus.cap_instr;
         wdata_mem[wr_ptr] <= bus.cap_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         count      <= '0;
         overflow   <= 1'b0;
         retire_cnt <= '0;
         wr_ptr     <= '0;
         post_cnt   <= '0;
      end else begin
         if (bus.cap_valid)
            retire_cnt <= retire_cnt + 32'd1;

         if (arm) begin
            state    <= S_ARMED;
            count    <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            post_cnt <= '0;
         end else begin
            case (state)
               S_ARMED, S_POST: begin
                  if (cap_en) begin
                     wr_ptr <= wr_ptr + AW'(1);
                     if (full)
                        overflow <= 1'b1;
                     else
                        count <= count + (AW+1)'(1);

                     if (state == S_ARMED) begin
                        if (trig_hit) begin
                           if (POST_TRIG == 0) begin
                              state <= S_DONE;
                           end else begin
                              state    <= S_POST;
                              post_cnt <= AW'(POST_TRIG);
                           end
                        end
                     end else begin
                        post_cnt <= post_cnt - AW'(1);
                        if (post_cnt == AW'(1))
                           state <= S_DONE;
                     end
                  end
               end
               S_DONE: begin
                  if (rd_fire)
                     count <= count - (AW+1)'(1);
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      bus.rd_valid = 1'b0;
      bus.rd_pc    = '0;
      bus.rd_instr = '0;
      bus.rd_wdata = '0;
      if (state == S_DONE && count != '0) begin
         bus.rd_valid = 1'b1;
         bus.rd_pc    = pc_mem[rd_ptr];
         bus.rd_instr = instr_mem[rd_ptr];
         bus.rd_wdata = wdata_mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_riscv_trace_buffer.sv
module tb_riscv_trace_buffer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   riscv_trace_buffer_if #(.XLEN(32)) b0 ();
   riscv_trace_buffer_if #(.XLEN(32)) b1 ();

   logic        arm0, trig_en0, arm1, trig_en1;
   logic [31:0] trig_pc0, trig_pc1;
   logic [1:0]  state0, state1;
   logic [4:0]  count0, count1;
   logic        overflow0, overflow1;
   logic [31:0] retire_cnt0, retire_cnt1;

   riscv_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(4)) u0 (
      .clk(clk), .reset(reset), .bus(b0), .arm(arm0), .trig_en(trig_en0),
      .trig_pc(trig_pc0), .state(state0), .count(count0),
      .overflow(overflow0), .retire_cnt(retire_cnt0));

   riscv_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(0)) u1 (
      .clk(clk), .reset(reset), .bus(b1), .arm(arm1), .trig_en(trig_en1),
      .trig_pc(trig_pc1), .state(state1), .count(count1),
      .overflow(overflow1), .retire_cnt(retire_cnt1));

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [31:0] exp_instr(input logic [31:0] pc);
      return pc ^ 32'h1300_0013;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] pc);
      return (pc * 32'd3) + 32'hA5A5_0001;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire0(input logic [31:0] pc);
      b0.cap_valid = 1'b1;
      b0.cap_pc    = pc;
      b0.cap_instr = exp_instr(pc);
      b0.cap_wdata = exp_wdata(pc);
      tick();
      b0.cap_valid = 1'b0;
   endtask

   task automatic retire1(input logic [31:0] pc);
      b1.cap_valid = 1'b1;
      b1.cap_pc    = pc;
      b1.cap_instr = exp_instr(pc);
      b1.cap_wdata = exp_wdata(pc);
      tick();
      b1.cap_valid = 1'b0;
   endtask

   task automatic pulse_arm0();
      arm0 = 1'b1;
      tick();
      arm0 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      vectors++; if (state0 !== 2'd0) begin miscompares++; $display("FAIL reset_state0: got %0d expected 0", state0); end
      vectors++; if (count0 !== 5'd0) begin miscompares++; $display("FAIL reset_count0: got %0d expected 0", count0); end
      vectors++; if (b0.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid0: got %b expected 0", b0.rd_valid); end
      vectors++; if (overflow0 !== 1'b0) begin miscompares++; $display("FAIL reset_overflow0: got %b expected 0", overflow0); end
      vectors++; if (retire_cnt0 !== 32'd0) begin miscompares++; $display("FAIL reset_retire_cnt0: got %0h expected 0", retire_cnt0); end
      vectors++; if ({b0.rd_pc, b0.rd_instr, b0.rd_wdata} !== 96'd0) begin miscompares++; $display("FAIL reset_rd_data0: got %0h/%0h/%0h expected 0", b0.rd_pc, b0.rd_instr, b0.rd_wdata); end
      vectors++; if (state1 !== 2'd0 || count1 !== 5'd0 || b1.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_u1: got state %0d count %0d rd_valid %b expected 0/0/0", state1, count1, b1.rd_valid); end
   endtask

   task automatic test_trigger_readout();
      logic [31:0] pc;
      trig_en0 = 1'b1;
      trig_pc0 = 32'h10;
      pulse_arm0();
      vectors++; if (state0 !== 2'd1) begin miscompares++; $display("FAIL arm_state: got %0d expected 1", state0); end
      for (int i = 0; i < 9; i++) begin
         retire0(32'(i * 4));
         if (i == 4) begin
            vectors++; if (state0 !== 2'd2) begin miscompares++; $display("FAIL trig_to_post: got %0d expected 2", state0); end
         end
         if (i == 7) begin
            vectors++; if (state0 !== 2'd2) begin miscompares++; $display("FAIL post_hold: got %0d expected 2", state0); end
         end
      end
      vectors++; if (state0 !== 2'd3) begin miscompares++; $display("FAIL done_state: got %0d expected 3", state0); end
      vectors++; if (count0 !== 5'd9) begin miscompares++; $display("FAIL done_count: got %0d expected 9", count0); end
      vectors++; if (overflow0 !== 1'b0) begin miscompares++; $display("FAIL done_overflow: got %b expected 0", overflow0); end
      vectors++; if (retire_cnt0 !== 32'd9) begin miscompares++; $display("FAIL retire_cnt9: got %0d expected 9", retire_cnt0); end
      // DONE must ignore further retires.
      retire0(32'h500);
      vectors++; if (count0 !== 5'd9) begin miscompares++; $display("FAIL done_no_capture: got %0d expected 9", count0); end
      b0.rd_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         pc = 32'(i * 4);
         vectors++; if (b0.rd_valid !== 1'b1 || b0.rd_pc !== pc) begin miscompares++; $display("FAIL read_pc[%0d]: got v=%b pc=%0h expected v=1 pc=%0h", i, b0.rd_valid, b0.rd_pc, pc); end
         vectors++; if (b0.rd_instr !== exp_instr(pc) || b0.rd_wdata !== exp_wdata(pc)) begin miscompares++; $display("FAIL read_data[%0d]: got %0h/%0h expected %0h/%0h", i, b0.rd_instr, b0.rd_wdata, exp_instr(pc), exp_wdata(pc)); end
         tick();
      end
      b0.rd_ready = 1'b0;
      vectors++; if (count0 !== 5'd0 || b0.rd_valid !== 1'b0) begin miscompares++; $display("FAIL drained: got count %0d rd_valid %b expected 0/0", count0, b0.rd_valid); end
   endtask

   task automatic test_overflow();
      logic [31:0] pc;
      trig_pc0 = 32'h40;
      pulse_arm0();
      for (int i = 0; i < 21; i++) retire0(32'(i * 4));
      vectors++; if (state0 !== 2'd3) begin miscompares++; $display("FAIL ovf_state: got %0d expected 3", state0); end
      vectors++; if (count0 !== 5'd16) begin miscompares++; $display("FAIL ovf_count: got %0d expected 16", count0); end
      vectors++; if (overflow0 !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", overflow0); end
      b0.rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pc = 32'h14 + 32'(i * 4);
         vectors++; if (b0.rd_valid !== 1'b1 || b0.rd_pc !== pc || b0.rd_wdata !== exp_wdata(pc)) begin miscompares++; $display("FAIL ovf_read[%0d]: got v=%b pc=%0h expected v=1 pc=%0h", i, b0.rd_valid, b0.rd_pc, pc); end
         tick();
      end
      b0.rd_ready = 1'b0;
      vectors++; if (count0 !== 5'd0 || b0.rd_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got count %0d rd_valid %b expected 0/0", count0, b0.rd_valid); end
      pulse_arm0();
      vectors++; if (overflow0 !== 1'b0 || count0 !== 5'd0) begin miscompares++; $display("FAIL arm_clears_ovf: got ovf %b count %0d expected 0/0", overflow0, count0); end
   endtask

   task automatic test_backpressure();
      trig_pc0 = 32'h200;
      pulse_arm0();
      for (int i = 0; i < 5; i++) retire0(32'h200 + 32'(i * 4));
      vectors++; if (state0 !== 2'd3 || count0 !== 5'd5) begin miscompares++; $display("FAIL bp_setup: got state %0d count %0d expected 3/5", state0, count0); end
      b0.rd_ready = 1'b1;
      tick();
      tick();
      b0.rd_ready = 1'b0;
      vectors++; if (count0 !== 5'd3 || b0.rd_pc !== 32'h208) begin miscompares++; $display("FAIL bp_after2: got count %0d pc %0h expected 3/208", count0, b0.rd_pc); end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if (b0.rd_valid !== 1'b1 || b0.rd_pc !== 32'h208 || count0 !== 5'd3) begin miscompares++; $display("FAIL bp_hold[%0d]: got v=%b pc=%0h count=%0d expected 1/208/3", i, b0.rd_valid, b0.rd_pc, count0); end
      end
      b0.rd_ready = 1'b1; tick();
      b0.rd_ready = 1'b0; tick();
      b0.rd_ready = 1'b1; tick();
      b0.rd_ready = 1'b0;
      vectors++; if (count0 !== 5'd1 || b0.rd_pc !== 32'h210) begin miscompares++; $display("FAIL bp_toggle: got count %0d pc %0h expected 1/210", count0, b0.rd_pc); end
   endtask

   task automatic test_reset_in_post();
      trig_pc0 = 32'h100;
      pulse_arm0();
      retire0(32'h100);
      retire0(32'h104);
      retire0(32'h108);
      vectors++; if (state0 !== 2'd2 || count0 !== 5'd3) begin miscompares++; $display("FAIL post_setup: got state %0d count %0d expected 2/3", state0, count0); end
      reset = 1'b1;
      b0.cap_valid = 1'b1;
      b0.cap_pc    = 32'h10C;
      tick();
      reset = 1'b0;
      b0.cap_valid = 1'b0;
      vectors++; if (state0 !== 2'd0 || count0 !== 5'd0 || b0.rd_valid !== 1'b0 || retire_cnt0 !== 32'd0) begin miscompares++; $display("FAIL post_reset: got state %0d count %0d v %b rc %0d expected 0/0/0/0", state0, count0, b0.rd_valid, retire_cnt0); end
      for (int i = 0; i < 3; i++) retire0(32'h100);
      vectors++; if (state0 !== 2'd0 || count0 !== 5'd0) begin miscompares++; $display("FAIL idle_no_capture: got state %0d count %0d expected 0/0", state0, count0); end
      vectors++; if (retire_cnt0 !== 32'd3) begin miscompares++; $display("FAIL idle_retire_cnt: got %0d expected 3", retire_cnt0); end
   endtask

   task automatic test_post_trig_zero();
      logic [31:0] seq [5];
      seq[0] = 32'h10; seq[1] = 32'h14; seq[2] = 32'h18; seq[3] = 32'h1C; seq[4] = 32'h08;
      trig_en1 = 1'b1;
      trig_pc1 = 32'h08;
      arm1 = 1'b1; tick(); arm1 = 1'b0;
      for (int i = 0; i < 5; i++) retire1(seq[i]);
      vectors++; if (state1 !== 2'd3 || count1 !== 5'd5) begin miscompares++; $display("FAIL pt0_done: got state %0d count %0d expected 3/5", state1, count1); end
      b1.rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vectors++; if (b1.rd_valid !== 1'b1 || b1.rd_pc !== seq[i] || b1.rd_instr !== exp_instr(seq[i])) begin miscompares++; $display("FAIL pt0_read[%0d]: got v=%b pc=%0h expected v=1 pc=%0h", i, b1.rd_valid, b1.rd_pc, seq[i]); end
         tick();
      end
      b1.rd_ready = 1'b0;
      arm1 = 1'b1; tick(); arm1 = 1'b0;
      for (int i = 0; i < 5; i++) retire1(seq[i]);
      vectors++; if (state1 !== 2'd3 || count1 !== 5'd5) begin miscompares++; $display("FAIL pt0_redone: got state %0d count %0d expected 3/5", state1, count1); end
      arm1 = 1'b1;
      b1.rd_ready  = 1'b1;
      b1.cap_valid = 1'b1;
      b1.cap_pc    = 32'h20;
      tick();
      arm1 = 1'b0;
      b1.rd_ready  = 1'b0;
      b1.cap_valid = 1'b0;
      vectors++; if (state1 !== 2'd1 || count1 !== 5'd0 || b1.rd_valid !== 1'b0) begin miscompares++; $display("FAIL pt0_rearm: got state %0d count %0d v %b expected 1/0/0", state1, count1, b1.rd_valid); end
      tick();
      vectors++; if (count1 !== 5'd0) begin miscompares++; $display("FAIL pt0_arm_cap: got count %0d expected 0", count1); end
      vectors++; if (retire_cnt1 !== 32'd11) begin miscompares++; $display("FAIL pt0_retire_cnt: got %0d expected 11", retire_cnt1); end
   endtask

   initial begin
      reset = 1'b1;
      arm0 = 1'b0; trig_en0 = 1'b0; trig_pc0 = '0;
      arm1 = 1'b0; trig_en1 = 1'b0; trig_pc1 = '0;
      b0.cap_valid = 1'b0; b0.cap_pc = '0; b0.cap_instr = '0; b0.cap_wdata = '0; b0.rd_ready = 1'b0;
      b1.cap_valid = 1'b0; b1.cap_pc = '0; b1.cap_instr = '0; b1.cap_wdata = '0; b1.rd_ready = 1'b0;
      test_reset();
      test_trigger_readout();
      test_overflow();
      test_backpressure();
      test_reset_in_post();
      test_post_trig_zero();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
